fp_simd_issuer: RTL

FP_SIMD_ISSUER -- requirements
Module: fp_simd_issuer

---
 rtl/fp_simd_issuer_pkg.sv | 39 +++
 rtl/fp_cmd_fifo.sv | 56 +++++
 rtl/fp_simd_issuer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fp_simd_issuer_pkg.sv
// Shared types for the FP SIMD issuer: lane geometry, opcodes, FSM states, queued command layout.
package fp_simd_issuer_pkg;

  localparam int LANE_W     = 22;
  localparam int SIMD_LANES = 4;
  localparam int DATA_W     = LANE_W * SIMD_LANES;

  typedef enum logic [2:0] {
    OP_ADD        = 3'b000,
    OP_SUB        = 3'b001,
    OP_MUL        = 3'b010,
    OP_RCP        = 3'b011,
    OP_REDUCE_ADD = 3'b100,
    OP_REDUCE_MUL = 3'b101,
    OP_LOAD1      = 3'b110,
    OP_LOAD2      = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    opcode_e             opcode;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Loads finish inside the issue cycle; the SIMD unit never reports them back.
  function automatic logic is_load(input opcode_e op);
    return (op == OP_LOAD1) || (op == OP_LOAD2);
  endfunction

endpackage

// File: rtl/fp_cmd_fifo.sv
// Synchronous command FIFO, show-ahead head (zero when empty); push ignored when full, pop ignored when empty.
module fp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_din;
    end
  end

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fp_simd_issuer.sv
// Queues SIMD commands and issues them one at a time; the head stays queued until its result (or timeout)
// so the operands seen by the SIMD unit are stable for the whole operation. Result held until i_rsp_ready.
module fp_simd_issuer
  import fp_simd_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_opcode,
  input  logic [DATA_W-1:0] i_cmd_a,
  input  logic [DATA_W-1:0] i_cmd_b,
  output logic              o_simd_en,
  output logic [2:0]        o_simd_opcode,
  output logic [DATA_W-1:0] o_simd_in1,
  output logic [DATA_W-1:0] o_simd_in2,
  input  logic              i_simd_busy,
  input  logic              i_simd_valid,
  input  logic [DATA_W-1:0] i_simd_output,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [2:0]        o_rsp_opcode,
  output logic              o_idle,
  output logic              o_err_timeout
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  cmd_t               cmd_in, head;
  logic [CMD_W-1:0]   head_raw;
  logic               fifo_full, fifo_empty, pop;
  logic [FCNT_W-1:0]  fifo_count;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               simd_en_q, simd_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [2:0]         rsp_opcode_q, rsp_opcode_d;
  logic               err_q, err_d;

  assign cmd_in = cmd_t'({i_cmd_opcode, i_cmd_a, i_cmd_b});
  assign head   = cmd_t'(head_raw);

  fp_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_cmd_valid),
    .i_din   (cmd_in),
    .i_pop   (pop),
    .o_dout  (head_raw),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_opcode_d = rsp_opcode_q;
    err_d        = err_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !i_simd_busy) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        if (is_load(head.opcode)) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_simd_valid) begin
          rsp_data_d   = i_simd_output;
          rsp_opcode_d = head.opcode;
          rsp_valid_d  = 1'b1;
          pop          = 1'b1;
          state_d      = ST_RESP;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    simd_en_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      simd_en_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_opcode_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      simd_en_q    <= simd_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_opcode_q <= rsp_opcode_d;
      err_q        <= err_d;
    end
  end

  // Head is not popped until WAIT exits, so these hold the in-flight command throughout.
  assign o_simd_opcode = head.opcode;
  assign o_simd_in1    = head.a;
  assign o_simd_in2    = head.b;

  assign o_simd_en     = simd_en_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_opcode  = rsp_opcode_q;
  assign o_err_timeout = err_q;
  assign o_cmd_ready   = !fifo_full;
  assign o_idle        = (state_q == ST_IDLE) && (fifo_count == '0);

endmodule
